// File: rtl/gated_xor_pipe.sv
// gated_xor_pipe
//   Registered, multi-lane gated-XOR stage: f[i] = (c[i] | ~d[i]) & (a[i] ^ b[i]).
//   Two-stage valid/ready pipeline (2-cycle latency, 1 beat/cycle). It reports
//   the per-beat popcount of f and a saturating running total over the output
//   beats that downstream accepts.
//
//   Optional feature macro: GXP_PARITY_EN
//     defined   -> output f_par = ^f, registered together with f.
//     undefined -> no f_par port or logic.
//
// Parameters
//   WIDTH  lanes per beat (>= 1)
//   TOT_W  ones_total width (>= CNT_W)
//   CNT_W  derived, $clog2(WIDTH+1), not overridable
//
// Ports
//   clk, rst             clock (rising edge), synchronous active-high reset
//   in_valid / in_ready  upstream handshake; in_ready is combinational from out_ready
//   a, b, c, d           lane operands, sampled only on the input handshake
//   out_valid/out_ready  downstream handshake
//   f, f_count           per-lane result and its popcount
//   clear_total          synchronous clear of ones_total
//   ones_total           saturating sum of f_count over accepted output beats
//   f_par                (GXP_PARITY_EN only) parity of f
module gated_xor_pipe #(
  parameter  int unsigned WIDTH = 4,
  parameter  int unsigned TOT_W = 16,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic [CNT_W-1:0] f_count,
  input  logic             clear_total,
  output logic [TOT_W-1:0] ones_total
`ifdef GXP_PARITY_EN
  ,
  output logic             f_par
`endif
);

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_f_raw;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_f;
  logic [CNT_W-1:0] r_f_count;
  logic [TOT_W-1:0] r_total;

  logic             w_s2_en;
  logic             w_s1_en;
  logic             w_in_hs;
  logic             w_out_hs;
  logic [WIDTH-1:0] w_f_lane;
  logic [CNT_W-1:0] w_pop;
  logic [TOT_W-1:0] w_base;
  logic [TOT_W:0]   w_cnt_ext;
  logic [TOT_W:0]   w_sum;
  logic [TOT_W-1:0] w_sat;

  // Each stage loads when empty or when its occupant leaves this cycle.
  assign w_s2_en  = !r_out_valid || out_ready;
  assign w_s1_en  = !r_s1_valid || w_s2_en;
  assign w_in_hs  = in_valid && w_s1_en;
  assign w_out_hs = r_out_valid && out_ready;

  assign w_f_lane = (c | ~d) & (a ^ b);

  always_comb begin
    w_pop = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + CNT_W'(r_f_raw[i]);
    end
  end

  // Stage 1: lane vector captured only on the input handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_f_raw    <= '0;
    end else if (w_s1_en) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_f_raw <= w_f_lane;
      end
    end
  end

  // Stage 2: output registers hold while stalled (out_valid & !out_ready).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_f         <= '0;
      r_f_count   <= '0;
    end else if (w_s2_en) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_f       <= r_f_raw;
        r_f_count <= w_pop;
      end
    end
  end

  // Clear is applied before the beat is added, so a clear coinciding with
  // an output handshake leaves exactly that beat's count.
  always_comb begin
    w_base    = clear_total ? '0 : r_total;
    w_cnt_ext = '0;
    w_cnt_ext[CNT_W-1:0] = r_f_count;
    w_sum     = {1'b0, w_base} + w_cnt_ext;
    w_sat     = w_sum[TOT_W] ? '1 : w_sum[TOT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_total <= '0;
    end else if (w_out_hs) begin
      r_total <= w_sat;
    end else if (clear_total) begin
      r_total <= '0;
    end
  end

  assign in_ready   = w_s1_en;
  assign out_valid  = r_out_valid;
  assign f          = r_f;
  assign f_count    = r_f_count;
  assign ones_total = r_total;

`ifdef GXP_PARITY_EN
  logic r_par;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_par <= 1'b0;
    end else if (w_s2_en && r_s1_valid) begin
      r_par <= ^r_f_raw;
    end
  end

  assign f_par = r_par;
`endif

endmodule
